// File: rtl/dmem_arbiter_if.sv
// Request/response handshake for the two data-memory requesters plus the
// memory-side strobes. The arbiter uses the slave view; the requesters use master.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [31:0]       req0_wdata;
  logic [2:0]        req0_funct3;
  logic              rsp0_valid;
  logic [31:0]       rsp0_rdata;
  logic              rsp0_err;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [31:0]       req1_wdata;
  logic [2:0]        req1_funct3;
  logic              rsp1_valid;
  logic [31:0]       rsp1_rdata;
  logic              rsp1_err;

  logic              mem_MemWrite;
  logic              mem_MemRead;
  logic [31:0]       mem_address;
  logic [31:0]       mem_write_data;
  logic [2:0]        mem_funct3;
  logic [31:0]       mem_read_data;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata, req0_funct3,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_valid, req1_write, req1_addr, req1_wdata, req1_funct3,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_MemWrite, mem_MemRead, mem_address, mem_write_data, mem_funct3,
    input  mem_read_data
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata, req0_funct3,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_valid, req1_write, req1_addr, req1_wdata, req1_funct3,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_MemWrite, mem_MemRead, mem_address, mem_write_data, mem_funct3,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the LSU (port 0)
// and the debug/DMA loader (port 1); each access takes IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t            state_reg, state_next;
  logic              last_grant_reg;
  logic              grant;
  logic              accept;
  logic              idle_live;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_funct3;
  logic [2:0]        sel_size;
  logic [ADDR_W:0]   sel_end;
  logic              f3_ok, misaligned, out_of_range, sel_err;

  logic              write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [2:0]        funct3_reg;
  logic              port_reg;
  logic              err_reg;
  logic [31:0]       rdata_reg;

  logic              access_live, resp_live;

  // Contention goes to whichever port did not win last time.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_reg;
    else                                  grant = bus.req1_valid;
  end

  assign idle_live      = (state_reg == IDLE) && !rst;
  assign bus.req0_ready = idle_live && bus.req0_valid && !grant;
  assign bus.req1_ready = idle_live && bus.req1_valid && grant;
  assign accept         = bus.req0_ready || bus.req1_ready;

  assign sel_write  = grant ? bus.req1_write  : bus.req0_write;
  assign sel_addr   = grant ? bus.req1_addr   : bus.req0_addr;
  assign sel_wdata  = grant ? bus.req1_wdata  : bus.req0_wdata;
  assign sel_funct3 = grant ? bus.req1_funct3 : bus.req0_funct3;

  always_comb begin
    f3_ok = 1'b0;
    case (sel_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !sel_write;
      default:                f3_ok = 1'b0;
    endcase
    case (sel_funct3[1:0])
      2'b00:   sel_size = 3'd1;
      2'b01:   sel_size = 3'd2;
      default: sel_size = 3'd4;
    endcase
    misaligned = ((sel_funct3[1:0] == 2'b01) && sel_addr[0]) ||
                 ((sel_funct3[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00));
    // One extra bit keeps addresses near the top of the space from wrapping.
    sel_end      = {1'b0, sel_addr} + (ADDR_W+1)'(sel_size);
    out_of_range = sel_end > MEM_LIMIT;
    sel_err      = !f3_ok || misaligned || out_of_range;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      write_reg      <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      funct3_reg     <= '0;
      port_reg       <= 1'b0;
      err_reg        <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        last_grant_reg <= grant;
        port_reg       <= grant;
        write_reg      <= sel_write;
        addr_reg       <= sel_addr;
        wdata_reg      <= sel_wdata;
        funct3_reg     <= sel_funct3;
        err_reg        <= sel_err;
      end
      if (state_reg == ACCESS)
        rdata_reg <= (!write_reg && !err_reg) ? bus.mem_read_data : 32'd0;
    end
  end

  // Strobes are gated by rst so a store caught by reset never commits.
  assign access_live        = (state_reg == ACCESS) && !rst && !err_reg;
  assign bus.mem_MemRead    = access_live && !write_reg;
  assign bus.mem_MemWrite   = access_live && write_reg;
  assign bus.mem_address    = 32'(addr_reg);
  assign bus.mem_write_data = wdata_reg;
  assign bus.mem_funct3     = funct3_reg;

  assign resp_live      = (state_reg == RESP) && !rst;
  assign bus.rsp0_valid = resp_live && !port_reg;
  assign bus.rsp1_valid = resp_live && port_reg;
  assign bus.rsp0_rdata = bus.rsp0_valid ? rdata_reg : 32'd0;
  assign bus.rsp1_rdata = bus.rsp1_valid ? rdata_reg : 32'd0;
  assign bus.rsp0_err   = bus.rsp0_valid && err_reg;
  assign bus.rsp1_err   = bus.rsp1_valid && err_reg;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array memory model that applies
// funct3 size/sign handling on reads and byte-lane writes on stores.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   strobe_cnt = 0;

  logic [7:0]  mem [0:4095];
  logic [7:0]  rb [4];
  logic [31:0] ra;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32)) bus ();

  dmem_arbiter #(.MEM_BYTES(4096), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always_comb begin
    ra = 32'd0;
    for (int i = 0; i < 4; i++) begin
      ra    = bus.mem_address + 32'(i);
      rb[i] = (ra < 32'd4096) ? mem[ra[11:0]] : 8'h00;
    end
    case (bus.mem_funct3)
      3'b000:  bus.mem_read_data = {{24{rb[0][7]}}, rb[0]};
      3'b001:  bus.mem_read_data = {{16{rb[1][7]}}, rb[1], rb[0]};
      3'b010:  bus.mem_read_data = {rb[3], rb[2], rb[1], rb[0]};
      3'b100:  bus.mem_read_data = {24'd0, rb[0]};
      3'b101:  bus.mem_read_data = {16'd0, rb[1], rb[0]};
      default: bus.mem_read_data = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_MemWrite) begin
      case (bus.mem_funct3[1:0])
        2'b00: mem[bus.mem_address[11:0]] <= bus.mem_write_data[7:0];
        2'b01: begin
          mem[bus.mem_address[11:0]]         <= bus.mem_write_data[7:0];
          mem[bus.mem_address[11:0] + 12'd1] <= bus.mem_write_data[15:8];
        end
        default: begin
          mem[bus.mem_address[11:0]]         <= bus.mem_write_data[7:0];
          mem[bus.mem_address[11:0] + 12'd1] <= bus.mem_write_data[15:8];
          mem[bus.mem_address[11:0] + 12'd2] <= bus.mem_write_data[23:16];
          mem[bus.mem_address[11:0] + 12'd3] <= bus.mem_write_data[31:24];
        end
      endcase
    end
  end

  always @(negedge clk) strobe_cnt += int'(bus.mem_MemWrite) + int'(bus.mem_MemRead);

  initial begin
    #400000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int port, input logic v, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3);
    if (port == 0) begin
      bus.req0_valid = v; bus.req0_write = wr; bus.req0_addr = addr;
      bus.req0_wdata = wd; bus.req0_funct3 = f3;
    end else begin
      bus.req1_valid = v; bus.req1_write = wr; bus.req1_addr = addr;
      bus.req1_wdata = wd; bus.req1_funct3 = f3;
    end
  endtask

  // One access on a single port; called at a negedge with the arbiter idle.
  task automatic xact(input string tag, input int port, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int s0;
    logic rdy, ordy, rv, orv;
    logic [31:0] rd;
    logic re;
    s0 = strobe_cnt;
    drive(port, 1'b1, wr, addr, wd, f3);
    n = 0;
    #1;
    rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
    while (!rdy && n < 10) begin
      @(negedge clk); #1; n++;
      rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
    end
    ordy = (port == 0) ? bus.req1_ready : bus.req0_ready;
    chk({tag, "_ready"}, 32'(rdy), 32'd1);
    chk({tag, "_other_ready"}, 32'(ordy), 32'd0);
    @(negedge clk);
    drive(port, 1'b0, wr, addr, wd, f3);
    #1;
    rv = (port == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    chk({tag, "_access_wr"}, 32'(bus.mem_MemWrite), 32'(wr && !exp_err));
    chk({tag, "_access_rd"}, 32'(bus.mem_MemRead), 32'(!wr && !exp_err));
    chk({tag, "_early_rsp"}, 32'(rv), 32'd0);
    @(negedge clk); #1;
    rv  = (port == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    orv = (port == 0) ? bus.rsp1_valid : bus.rsp0_valid;
    rd  = (port == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
    re  = (port == 0) ? bus.rsp0_err   : bus.rsp1_err;
    chk({tag, "_rsp_valid"}, 32'(rv), 32'd1);
    chk({tag, "_other_rsp"}, 32'(orv), 32'd0);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(re), 32'(exp_err));
    chk({tag, "_strobes"}, 32'(strobe_cnt - s0), exp_err ? 32'd0 : 32'd1);
    $display("xact %s port=%0d wr=%0d addr=%h f3=%b rdata=%h err=%0d", tag, port, wr, addr, f3, rd, re);
    @(negedge clk);
  endtask

  int grants [6];
  int gcyc [6];
  int ng;
  int cyc;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b010);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'b010);

    // Reset state, including a valid request that must be ignored while rst is high
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
    chk("rst_rsp0", 32'(bus.rsp0_valid), 32'd0);
    chk("rst_strobes", 32'({bus.mem_MemWrite, bus.mem_MemRead}), 32'd0);
    chk("rst_address", bus.mem_address, 32'd0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Both ports valid continuously: grants must alternate starting with port 0
    drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
    drive(1, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
    ng = 0;
    cyc = 0;
    while (ng < 6 && cyc < 40) begin
      #1;
      chk("rr_both_ready", 32'(bus.req0_ready && bus.req1_ready), 32'd0);
      if (bus.req0_ready || bus.req1_ready) begin
        grants[ng] = int'(bus.req1_ready);
        gcyc[ng]   = cyc;
        $display("rr grant %0d -> port %0d at cycle %0d", ng, grants[ng], cyc);
        ng++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("rr_grant_count", 32'(ng), 32'd6);
    for (int i = 0; i < ng; i++) begin
      chk("rr_grant_port", 32'(grants[i]), 32'(i % 2));
      if (i > 0) chk("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end
    @(negedge clk); #1;
    chk("rr_last_rsp1", 32'(bus.rsp1_valid), 32'd1);
    @(negedge clk);

    // Word store/load round trip
    xact("sw_10",  0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'd0, 1'b0);
    xact("lw_10",  0, 1'b0, 32'h10, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0);

    // Byte/halfword sizes and sign handling
    xact("sb_21",  1, 1'b1, 32'h21, 32'hAAAAAA80, 3'b000, 32'd0, 1'b0);
    xact("lb_21",  0, 1'b0, 32'h21, 32'd0, 3'b000, 32'hFFFFFF80, 1'b0);
    xact("lbu_21", 1, 1'b0, 32'h21, 32'd0, 3'b100, 32'h00000080, 1'b0);
    xact("sh_22",  0, 1'b1, 32'h22, 32'h55558001, 3'b001, 32'd0, 1'b0);
    xact("lh_22",  0, 1'b0, 32'h22, 32'd0, 3'b001, 32'hFFFF8001, 1'b0);
    xact("lhu_22", 1, 1'b0, 32'h22, 32'd0, 3'b101, 32'h00008001, 1'b0);
    xact("lw_20",  0, 1'b0, 32'h20, 32'd0, 3'b010, 32'h80018000, 1'b0);

    // Rejected accesses: no strobe, rdata 0, err 1
    xact("lw_13",    0, 1'b0, 32'h13, 32'd0, 3'b010, 32'd0, 1'b1);
    xact("lh_41",    1, 1'b0, 32'h41, 32'd0, 3'b001, 32'd0, 1'b1);
    xact("lw_4094",  0, 1'b0, 32'd4094, 32'd0, 3'b010, 32'd0, 1'b1);
    xact("sw_f3_4",  1, 1'b1, 32'h10, 32'h11111111, 3'b100, 32'd0, 1'b1);
    xact("ld_f3_3",  0, 1'b0, 32'h10, 32'd0, 3'b011, 32'd0, 1'b1);
    xact("lb_wrap",  1, 1'b0, 32'hFFFFFFFF, 32'd0, 3'b000, 32'd0, 1'b1);
    xact("lw_10_chk", 1, 1'b0, 32'h10, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0);

    // Top-of-memory boundary: last byte and last word are legal
    xact("lb_4095",  0, 1'b0, 32'd4095, 32'd0, 3'b000, 32'd0, 1'b0);
    xact("lw_4092",  1, 1'b0, 32'd4092, 32'd0, 3'b010, 32'd0, 1'b0);
    xact("lb_4096",  0, 1'b0, 32'd4096, 32'd0, 3'b000, 32'd0, 1'b1);

    // Reset during the ACCESS cycle of a port-1 store
    drive(1, 1'b1, 1'b1, 32'h30, 32'h12345678, 3'b010);
    #1;
    chk("rstmid_ready1", 32'(bus.req1_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.req1_valid = 1'b0;
    #1;
    chk("rstmid_wr_forced", 32'(bus.mem_MemWrite), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_rsp1", 32'(bus.rsp1_valid), 32'd0);
    chk("rstmid_rdata1", bus.rsp1_rdata, 32'd0);
    chk("rstmid_strobes", 32'({bus.mem_MemWrite, bus.mem_MemRead}), 32'd0);
    chk("rstmid_address", bus.mem_address, 32'd0);
    chk("rstmid_wdata", bus.mem_write_data, 32'd0);
    @(negedge clk); #1;
    chk("rstmid_late_rsp1", 32'(bus.rsp1_valid), 32'd0);
    chk("rstmid_mem30", {mem[12'h33], mem[12'h32], mem[12'h31], mem[12'h30]}, 32'd0);
    $display("reset mid-access: rsp1_valid=%0d mem[0x30]=%h", bus.rsp1_valid, mem[12'h30]);
    @(negedge clk);
    xact("post_rst_lw", 1, 1'b0, 32'h30, 32'd0, 3'b010, 32'd0, 1'b0);
    xact("post_rst_sw", 0, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010, 32'd0, 1'b0);
    xact("post_rst_lw2", 1, 1'b0, 32'h30, 32'd0, 3'b010, 32'hCAFEF00D, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, byte-addressable data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA loader).
- Arbitrates round-robin and accepts requests over a valid/ready handshake.
- Sequences each access through a three-state FSM, drives the memory strobes/address/data/funct3, and returns a one-cycle response with read data or an error flag.
- Sits between the LSU/debug logic and the data memory; memory reads are combinational, writes commit on the clock edge.

Parameters:
- MEM_BYTES, 4096, memory size in bytes; valid addresses are 0 .. MEM_BYTES-1.
- ADDR_W, 32, request address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset (synchronous, active-high)
- reqN_valid  in  1  request valid, port N (N = 0, 1)
- reqN_ready  out  1  request accepted this cycle, port N
- reqN_write  in  1  1 = store, 0 = load
- reqN_addr  in  ADDR_W  byte address
- reqN_wdata  in  32  store data; low bytes used for sb/sh
- reqN_funct3  in  3  RISC-V size/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- rspN_valid  out  1  one-cycle response strobe
- rspN_rdata  out  32  load result; 0 for stores and errors
- rspN_err  out  1  access rejected, valid with rspN_valid
- mem_MemWrite  out  1  memory write strobe
- mem_MemRead  out  1  memory read strobe
- mem_address  out  32  memory byte address
- mem_write_data  out  32  memory write data
- mem_funct3  out  3  memory access size/sign
- mem_read_data  in  32  memory read data (combinational from address)

Behaviour:
- Clock and reset: one clock `clk`; synchronous active-high reset `rst`.
- Reset values: all outputs 0, FSM = IDLE, last_grant = 1 (so port 0 wins first).
- FSM states:
  - IDLE -> ACCESS on acceptance.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- Arbitration (IDLE only):
  - One requester valid: it is granted.
  - Both valid: the port that is not last_grant is granted.
  - last_grant updates on acceptance.
- Ready: reqN_ready = 1 only in IDLE, only for the granted port, combinational from the valids. Never 1 in ACCESS/RESP, and never for both ports at once.
- Acceptance edge: the granted port's write/addr/wdata/funct3 and the port id are latched. Requesters must not see acceptance otherwise.
- ACCESS cycle:
  - mem_address, mem_write_data and mem_funct3 are driven from the latched values.
  - mem_MemRead = !write && !err; mem_MemWrite = write && !err. Exactly one cycle.
  - On a load, mem_read_data is registered at the end of ACCESS.
- RESP cycle: rspN_valid = 1 for the latched port only, with rspN_rdata and rspN_err. There is no response backpressure.
- Latency: request accepted at edge k; ACCESS is cycle k+1; response is cycle k+2. Peak throughput is one access per 3 cycles.
- Error detection is computed at acceptance and latched; it suppresses both memory strobes. Any of the following sets err:
  - Illegal funct3. Loads allow 000/001/010/100/101; stores allow 000/001/010.
  - Misaligned access: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Out of range: addr + size > MEM_BYTES, with size 1/2/4, computed in ADDR_W+1 bits so there is no wrap.
- On error: rdata = 0, err = 1, same latency.
- Outside ACCESS: memory strobes are 0. address/data/funct3 hold their last value (don't-care).
- Stores: rspN_rdata = 0, err as computed.
- Reset mid-operation: while rst is high, the memory strobes are forced 0 combinationally, so no write commits in a reset cycle. The FSM returns to IDLE and any in-flight response is dropped.
- Simultaneous events: a requester may deassert valid only after seeing ready; the arbiter never takes a request whose valid dropped before acceptance.

Test Plan:
- Port 0 store sw addr 0x10 data 0xDEADBEEF, then load lw 0x10 -> MemWrite high for exactly one cycle; rsp0_valid 2 cycles after acceptance with rdata 0xDEADBEEF, err 0.
- Both ports assert valid every cycle for 6 accesses out of reset -> grants alternate 0,1,0,1,0,1; one acceptance per 3 cycles; ready never high for both ports at once.
- After sb 0x80 to addr 0x21: lb 0x21 -> rdata 0xFFFFFF80; lbu 0x21 -> 0x00000080. After sh 0x8001 to 0x22: lh 0x22 -> 0xFFFF8001.
- Each of: lw at 0x13, lh at 0x41, lw at 4094, sw with funct3 100, load with funct3 011 -> rsp err 1, rdata 0, and no mem strobe in any cycle.
- Assert rst during the ACCESS cycle of a port-1 sw to 0x30 -> memory at 0x30 unchanged; no rsp1_valid; all outputs 0 the cycle after reset; the next request is served normally.
